// File: rtl/r4_mm_test.sv
// r4_mm_test: self-contained 4x4 matrix-multiply test harness.
// After reset it computes C = A x B from two built-in constant matrices using a
// single serial multiply-accumulate unit (one MAC per cycle, 64 MACs).
// It then presents the row of C chosen by row_sel on the internal row_out register.
//   clk     : rising-edge clock
//   reset   : synchronous, active-high reset
//   row_sel : unsigned row index of C to present (0..3 valid; larger sets row_err)
// Internal observation signals: state, done, row_out, row_err, mac_count.
module r4_mm_test #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] row_sel
);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t                    state;
  state_t                    state_next;
  logic                      done;
  logic [4*ACC_W-1:0]        row_out;
  logic                      row_err;
  logic [5:0]                mac_count;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   c_mem [4][4];

  // mac_count = {i, j, k}, k innermost
  logic [1:0]                idx_i;
  logic [1:0]                idx_j;
  logic [1:0]                idx_k;
  logic                      mac_en;
  logic                      last_mac;
  logic signed [DATA_W-1:0]  a_val;
  logic signed [DATA_W-1:0]  b_val;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   mac_sum;

  assign idx_i = mac_count[5:4];
  assign idx_j = mac_count[3:2];
  assign idx_k = mac_count[1:0];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = COMPUTE;
      COMPUTE: if (mac_count == 6'd63) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Output / MAC-datapath combinational logic
  always_comb begin
    mac_en   = (state == COMPUTE);
    last_mac = mac_en && (mac_count == 6'd63);
    // A[i][k] = 4i + k + 1; {i,k} is exactly 4i + k
    a_val    = DATA_W'({idx_i, idx_k}) + DATA_W'(1);
    // B[k][j] = 2 on the diagonal, 1 just above it, else 0
    if (idx_k == idx_j)
      b_val = DATA_W'(2);
    else if ({1'b0, idx_j} == ({1'b0, idx_k} + 3'd1))
      b_val = DATA_W'(1);
    else
      b_val = '0;
    prod     = a_val * b_val;
    prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    mac_sum  = (idx_k == 2'd0) ? prod_ext : acc + prod_ext;
  end

  // Datapath and observation registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mac_count <= '0;
      acc       <= '0;
      done      <= 1'b0;
      row_out   <= '0;
      row_err   <= 1'b0;
      for (int unsigned r = 0; r < 4; r++)
        for (int unsigned c = 0; c < 4; c++)
          c_mem[r][c] <= '0;
    end else begin
      if (mac_en) begin
        acc       <= mac_sum;
        mac_count <= mac_count + 6'd1;
        if (idx_k == 2'd3) c_mem[idx_i][idx_j] <= mac_sum;
      end
      if (last_mac) done <= 1'b1;
      if (state == DONE) begin
        if (|row_sel[31:2]) begin
          row_out <= '0;
          row_err <= 1'b1;
        end else begin
          row_out <= {c_mem[row_sel[1:0]][3], c_mem[row_sel[1:0]][2],
                      c_mem[row_sel[1:0]][1], c_mem[row_sel[1:0]][0]};
          row_err <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_r4_mm_test.sv
`timescale 1ns/1ps
module tb_r4_mm_test;

  logic        clk;
  logic        reset;
  logic [31:0] row_sel;

  int checks;
  int errors;

  localparam logic [127:0] ROW0 = {32'd11, 32'd8,  32'd5,  32'd2};
  localparam logic [127:0] ROW1 = {32'd23, 32'd20, 32'd17, 32'd10};
  localparam logic [127:0] ROW2 = {32'd35, 32'd32, 32'd29, 32'd18};
  localparam logic [127:0] ROW3 = {32'd47, 32'd44, 32'd41, 32'd26};

  r4_mm_test #(.DATA_W(8), .ACC_W(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .row_sel (row_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_no_x(input string tag);
    logic bad;
    bad = $isunknown({dut.state, dut.done, dut.row_out, dut.row_err, dut.mac_count});
    check(tag, 128'(bad), 128'd0);
  endtask

  initial begin
    int n;
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    row_sel = 32'h0;

    // Reset values
    step();
    check("rst_state",   128'(dut.state), 128'd0);
    check("rst_done",    128'(dut.done), 128'd0);
    check("rst_row_out", dut.row_out, 128'd0);
    check("rst_row_err", 128'(dut.row_err), 128'd0);
    check("rst_mac",     128'(dut.mac_count), 128'd0);
    check_no_x("rst_nox");

    // Edge 1: IDLE -> COMPUTE
    reset = 1'b0;
    step();
    check("e1_state", 128'(dut.state), 128'd1);
    check("e1_mac",   128'(dut.mac_count), 128'd0);

    // Edges 2..64: done stays low, row_out stays 0, row_sel ignored
    for (int e = 2; e <= 64; e++) begin
      row_sel = 32'(e % 4);
      step();
      check("busy_done", 128'(dut.done), 128'd0);
      check("busy_row",  dut.row_out, 128'd0);
      if (e <= 10) check_no_x("busy_nox");
    end
    check("e64_mac", 128'(dut.mac_count), 128'd63);

    // Edge 65: done rises, state DONE, row_out not yet valid
    row_sel = 32'h0;
    step();
    check("e65_done",  128'(dut.done), 128'd1);
    check("e65_state", 128'(dut.state), 128'd2);
    check("e65_row",   dut.row_out, 128'd0);

    // Edge 66: first valid readout
    step();
    check("row0",     dut.row_out, ROW0);
    check("row0_err", 128'(dut.row_err), 128'd0);
    row_sel = 32'd1; step(); check("row1", dut.row_out, ROW1);
    row_sel = 32'd2; step(); check("row2", dut.row_out, ROW2);
    row_sel = 32'd3; step(); check("row3", dut.row_out, ROW3);

    // Out-of-range selects
    row_sel = 32'h0000_0005; step();
    check("oor5_row", dut.row_out, 128'd0);
    check("oor5_err", 128'(dut.row_err), 128'd1);
    row_sel = 32'h8000_0000; step();
    check("oor31_row", dut.row_out, 128'd0);
    check("oor31_err", 128'(dut.row_err), 128'd1);
    row_sel = 32'd2; step();
    check("back2_row", dut.row_out, ROW2);
    check("back2_err", 128'(dut.row_err), 128'd0);

    // Reset in DONE, restart, then reset again at mac_count = 30
    reset = 1'b1; step();
    check("rst2_done", 128'(dut.done), 128'd0);
    check("rst2_row",  dut.row_out, 128'd0);
    reset = 1'b0;
    n = 0;
    while (dut.mac_count != 6'd30 && n < 100) begin
      step();
      n++;
    end
    check("reach_mac30_edges", 128'(n), 128'd31);
    check("mid_c00", 128'(dut.c_mem[0][0]), 128'd2);
    reset = 1'b1; step();
    check("mid_rst_done",  128'(dut.done), 128'd0);
    check("mid_rst_row",   dut.row_out, 128'd0);
    check("mid_rst_c00",   128'(dut.c_mem[0][0]), 128'd0);
    check("mid_rst_c13",   128'(dut.c_mem[1][3]), 128'd0);
    check("mid_rst_state", 128'(dut.state), 128'd0);
    check("mid_rst_mac",   128'(dut.mac_count), 128'd0);

    // done must rise exactly 65 edges after release
    reset   = 1'b0;
    row_sel = 32'd3;
    n = 0;
    while (dut.done !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("restart_edges", 128'(n), 128'd65);
    step();
    check("restart_row3", dut.row_out, ROW3);
    row_sel = 32'd0; step();
    check("restart_row0", dut.row_out, ROW0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/r4_mm_test.md
# r4_mm_test

Self-contained 4×4 matrix-multiply test harness. It holds two constant operand matrices A and B, computes C = A×B with a single serial multiply-accumulate unit after reset, then presents a selected row of C on an internal register. The block is a top-level FPGA/simulation test wrapper with no functional outputs. Results are observed by hierarchical reference in simulation or by an on-chip logic analyzer.

## Interface
- DATA_W, 8: signed element width of A and B.
- ACC_W, 32: signed width of each C element and of the accumulator.
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  synchronous, active-high reset.
- row_sel  input  32  unsigned row index of C to present. Values 0..3 are valid.
- No other ports. The internal observation signals below are mandatory and must keep these names:
  - state: IDLE, COMPUTE, DONE.
  - done: 1 bit.
  - row_out: 4×ACC_W, with C[r][0] in the LSBs.
  - row_err: 1 bit.
  - mac_count: 6 bits.

## Operation
- Constant operands, in row i, column j notation:
  - A[i][j] = 4i + j + 1. Row 0 is 1,2,3,4 and row 3 is 13,14,15,16.
  - B[i][j] = 2 if i = j, 1 if j = i+1, else 0.
- Expected result: C[i][j] = 2·A[i][j] + A[i][j−1], where the A[i][j−1] term is 0 when j = 0.
  - Row 0: 2, 5, 8, 11.
  - Row 1: 10, 17, 20, 23.
  - Row 2: 18, 29, 32, 35.
  - Row 3: 26, 41, 44, 47.
- Arithmetic:
  - Each product is DATA_W×DATA_W signed, sign-extended to ACC_W.
  - Accumulation is in ACC_W with no saturation; wrap on overflow.
- FSM:
  - IDLE: unconditionally moves to COMPUTE on the next edge with reset low.
  - COMPUTE: one MAC per cycle. mac_count = {i, j, k} with k innermost, running 0..63.
    - When k = 0, the accumulator is loaded with the product.
    - Otherwise the product is added to the accumulator.
    - When k = 3, the final sum is written into C[i][j].
    - After mac_count = 63, move to DONE and set done = 1.
  - DONE: terminal state, left only by reset.
    - Each cycle, row_out ← row C[row_sel[1:0]] if row_sel < 4, and row_err ← 0.
    - If row_sel ≥ 4 (any of row_sel[31:2] set), row_out ← 0 and row_err ← 1.
- row_out and row_err hold at 0 until DONE.

## Timing
- Reset values, whenever reset is high at an edge:
  - state = IDLE, mac_count = 0, accumulator = 0.
  - All C elements = 0, done = 0, row_out = 0, row_err = 0.
- Cycle sequence:
  - Edge 1 after reset deasserts: IDLE→COMPUTE.
  - Edges 2–65: the 64 MACs.
  - Edge 65: writes C[3][3], state becomes DONE and done becomes 1.
  - Edge 66: first valid row_out.
- row_sel to row_out latency in DONE is 1 cycle (registered). row_sel is sampled every cycle; there is no handshake.
- Reset mid-COMPUTE or in DONE: the next edge applies reset values. Computation restarts from mac_count = 0 once reset is released and yields identical results.
- row_sel changes during IDLE or COMPUTE have no effect.

## Test plan
- Reset check: hold reset 1 cycle, then release. Check state = IDLE during reset; done, row_out and row_err are 0; done stays 0 through edge 64 and is 1 after edge 65.
- row_sel = 0: one cycle after done, row_out = {11, 8, 5, 2}, listed MSB→LSB in 32-bit fields; row_err = 0.
- Step row_sel through 1, 2, 3 on consecutive cycles: row_out follows one cycle later with {23,20,17,10}, {35,32,29,18}, {47,44,41,26}.
- row_sel = 32'h00000005, then 32'h80000000: row_out = 0 and row_err = 1 one cycle later. Returning to row_sel = 2 restores {35,32,29,18} with row_err = 0.
- Assert reset at mac_count = 30 for 1 cycle: done, C and row_out clear. done rises exactly 65 edges after release, and the row 3 readout is again {47,44,41,26}.
- Hold row_sel = 0x00000000 from time 0 with a 10-cycle bench: done remains 0, row_out remains 0, and no X appears on any internal observation signal.
